// File: rtl/mii_tx_scheduler_if.sv
// mii_tx_scheduler_if: config, status and generator-side signals of the MII TX scheduler
interface mii_tx_scheduler_if;
   logic        i_enable;
   logic [15:0] i_num_frames;
   logic [7:0]  i_ipg_cycles;
   logic [15:0] i_stop_data_frame;
   logic        i_stop_data_en;
   logic        i_abort;
   logic [7:0]  i_gen_data;
   logic        o_start;
   logic [7:0]  o_interrupt;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_frame_count;
   logic        o_timeout;
   modport master (
      output i_enable, i_num_frames, i_ipg_cycles, i_stop_data_frame, i_stop_data_en, i_abort, i_gen_data,
      input  o_start, o_interrupt, o_busy, o_done, o_frame_count, o_timeout
   );
   modport slave (
      input  i_enable, i_num_frames, i_ipg_cycles, i_stop_data_frame, i_stop_data_en, i_abort, i_gen_data,
      output o_start, o_interrupt, o_busy, o_done, o_frame_count, o_timeout
   );
endinterface

// File: rtl/mii_tx_scheduler.sv
// mii_tx_scheduler: frame start sequencing with IPG, frame counting and STOP_DATA injection; MII_SCHED_WATCHDOG_EN adds a per-frame watchdog
module mii_tx_scheduler #(
   parameter logic [7:0] START_CODE       = 8'hFB,
   parameter logic [7:0] TERMINATE_CODE   = 8'hFD,
   parameter logic [7:0] STOP_DATA_CODE   = 8'h02,
   parameter int         MAX_FRAME_CYCLES = 128
) (
   input logic            clk,
   input logic            i_rst,
   mii_tx_scheduler_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT_SOF, S_IN_FRAME, S_IPG, S_DONE
`ifdef MII_SCHED_WATCHDOG_EN
      , S_ERROR
`endif
   } state_t;
   state_t      state_q, state_d;
   logic        en_q, en_d;
   logic [15:0] num_q, num_d;
   logic [7:0]  ipg_q, ipg_d;
   logic [15:0] sdf_q, sdf_d;
   logic        sde_q, sde_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic        inj_q, inj_d;
   logic        sof, term;
`ifdef MII_SCHED_WATCHDOG_EN
   localparam int WDW = $clog2(MAX_FRAME_CYCLES + 1);
   logic [WDW-1:0] wd_q, wd_d;
   logic           timeout_q, timeout_d;
`endif
   assign sof  = bus.i_gen_data == START_CODE;
   assign term = bus.i_gen_data == TERMINATE_CODE;
   // next state, config latching, frame counting and registered injection match
   always_comb begin
      state_d = state_q;
      en_d    = bus.i_enable;
      num_d   = num_q;
      ipg_d   = ipg_q;
      sdf_d   = sdf_q;
      sde_d   = sde_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: if (bus.i_enable && !en_q) begin
            state_d = S_ARM;
            num_d   = bus.i_num_frames;
            ipg_d   = bus.i_ipg_cycles;
            sdf_d   = bus.i_stop_data_frame;
            sde_d   = bus.i_stop_data_en;
            cnt_d   = 16'd0;
         end
         S_ARM:      state_d = S_WAIT_SOF;
         S_WAIT_SOF: if (sof) state_d = S_IN_FRAME;
         S_IN_FRAME: if (term) begin
            cnt_d = cnt_q + 16'd1;
            if (bus.i_abort || (num_q != 16'd0 && cnt_d == num_q)) state_d = S_DONE;
            else if (ipg_q == 8'd0) state_d = S_ARM;
            else begin
               state_d = S_IPG;
               gap_d   = ipg_q - 8'd1;
            end
         end
         S_IPG: begin
            if (bus.i_abort) state_d = S_DONE;
            else if (gap_q == 8'd0) state_d = S_ARM;
            else gap_d = gap_q - 8'd1;
         end
         S_DONE: if (!bus.i_enable) state_d = S_IDLE;
         default: ;
      endcase
`ifdef MII_SCHED_WATCHDOG_EN
      timeout_d = timeout_q;
      wd_d = (state_q == S_ARM) ? '0 : (state_q == S_WAIT_SOF || state_q == S_IN_FRAME) ? wd_q + 1'b1 : wd_q;
      if ((state_q == S_WAIT_SOF || (state_q == S_IN_FRAME && !term)) && wd_q == WDW'(MAX_FRAME_CYCLES - 1)) begin
         state_d   = S_ERROR;
         timeout_d = 1'b1;
      end
`endif
      inj_d = sde_d && cnt_d == sdf_d && (state_d == S_ARM || state_d == S_WAIT_SOF || state_d == S_IN_FRAME);
   end
   // state and datapath registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
         num_q   <= 16'd0;
         ipg_q   <= 8'd0;
         sdf_q   <= 16'd0;
         sde_q   <= 1'b0;
         cnt_q   <= 16'd0;
         gap_q   <= 8'd0;
         inj_q   <= 1'b0;
`ifdef MII_SCHED_WATCHDOG_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         num_q   <= num_d;
         ipg_q   <= ipg_d;
         sdf_q   <= sdf_d;
         sde_q   <= sde_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         inj_q   <= inj_d;
`ifdef MII_SCHED_WATCHDOG_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end
   assign bus.o_start       = state_q == S_ARM;
   assign bus.o_busy        = state_q == S_ARM || state_q == S_WAIT_SOF || state_q == S_IN_FRAME || state_q == S_IPG;
   assign bus.o_done        = state_q == S_DONE;
   assign bus.o_interrupt   = inj_q ? STOP_DATA_CODE : 8'h00;
   assign bus.o_frame_count = cnt_q;
`ifdef MII_SCHED_WATCHDOG_EN
   assign bus.o_timeout = timeout_q;
`else
   assign bus.o_timeout = 1'b0;
`endif
endmodule

// File: doc/mii_tx_scheduler.md
# mii_tx_scheduler

Sequencing controller for the MII Ethernet frame generator. It issues start pulses to the generator and enforces a programmable inter-packet gap (IPG) between frames. It counts completed frames by watching the generator's output byte stream, and can inject the STOP_DATA interrupt into one selected frame. It sits between the test/config layer and the generator's `i_start`/`i_interrupt` inputs.

## Interface
Parameters:
- `START_CODE`, 8'hFB: byte marking start of frame on the generator output.
- `TERMINATE_CODE`, 8'hFD: byte marking end of frame.
- `STOP_DATA_CODE`, 8'h02: interrupt value driven for the selected frame.
- `MAX_FRAME_CYCLES`, 128: watchdog limit, counted from start pulse to terminate.

Ports:
- `clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_enable`  in  1  level; rising edge in IDLE starts a run.
- `i_num_frames`  in  16  frames per run; 0 means continuous.
- `i_ipg_cycles`  in  8  gap cycles between terminate and next start.
- `i_stop_data_frame`  in  16  0-based frame index that receives STOP_DATA.
- `i_stop_data_en`  in  1  enables interrupt injection.
- `i_abort`  in  1  level; request to stop after the current frame.
- `i_gen_data`  in  8  generator `o_tx_data`.
- `o_start`  out  1  to generator `i_start`.
- `o_interrupt`  out  8  to generator `i_interrupt`.
- `o_busy`  out  1  run in progress.
- `o_done`  out  1  run complete; held.
- `o_frame_count`  out  16  completed frames in current run.
- `o_timeout`  out  1  watchdog fired; sticky.

## Operation
- **States:** IDLE, ARM, WAIT_SOF, IN_FRAME, IPG, DONE, ERROR.
- **Config latching:** `i_num_frames`, `i_ipg_cycles`, `i_stop_data_frame` and `i_stop_data_en` are latched on the IDLE→ARM transition. Later changes are ignored until the next run.
- **IDLE:** `i_enable` rising edge (registered previous value was 0) → ARM. `o_frame_count` clears to 0 on this transition.
- **ARM:** one cycle, `o_start`=1. Unconditionally → WAIT_SOF.
- **WAIT_SOF:** `i_gen_data==START_CODE` → IN_FRAME.
- **IN_FRAME:** `i_gen_data==TERMINATE_CODE` increments `o_frame_count`. Then:
  - → DONE if `i_abort`=1, or if `i_num_frames`≠0 and the new count equals `i_num_frames`.
  - → ARM if `i_ipg_cycles`=0.
  - → IPG otherwise.
- **IPG:** counts `i_ipg_cycles` cycles, then → ARM. If `i_abort`=1 in IPG → DONE immediately, with no further start.
- **DONE:** `o_done`=1. `i_enable`=0 → IDLE.
- **ERROR:** → IDLE only on `i_rst`.
- **Abort:** `i_abort` in WAIT_SOF/IN_FRAME never truncates the frame; it is acted on at terminate. If abort and terminate occur in the same cycle, the frame is counted and the FSM goes to DONE.
- **Interrupt injection:** `o_interrupt` = STOP_DATA_CODE from ARM through the terminate cycle, when `i_stop_data_en`=1 and `o_frame_count==i_stop_data_frame`. Otherwise `o_interrupt` = 8'h00.
- **Counter wrap:** in continuous mode `o_frame_count` wraps 16'hFFFF→0. The injection match still applies after wrap.
- **Busy:** `o_busy`=1 in ARM, WAIT_SOF, IN_FRAME and IPG.
- **Deassertion:** `i_enable`=0 mid-run has no effect; runs are stopped only by `i_abort` or `i_rst`.

## Timing
- **Reset:** all outputs 0 and state=IDLE on the first clock edge with `i_rst`=1.
- **Output timing:** `o_start`, `o_busy`, `o_done` and `o_interrupt` are decoded from registered state and registered match flags; there is no combinational path from inputs to outputs.
- **Start latency:** `i_enable` rises at cycle E → `o_start`=1 at E+1 (single cycle). The generator then shows START_CODE at roughly E+3.
- **Terminate detection:** `i_gen_data==TERMINATE_CODE` sampled at cycle T.
  - `o_frame_count` updates at T+1.
  - The next `o_start` is at T+1+`i_ipg_cycles`.
- **Start pulse width:** `o_start` is never high on two consecutive cycles.

## Configuration
- **`MII_SCHED_WATCHDOG_EN` defined:**
  - A cycle counter runs in WAIT_SOF and IN_FRAME, reset in ARM.
  - When it reaches `MAX_FRAME_CYCLES` without a terminate, the FSM goes to ERROR: `o_timeout`=1 (sticky), `o_busy`=0, `o_start`=0, `o_interrupt`=0.
- **Not defined:** no counter and no ERROR state; `o_timeout` is tied to 0, and WAIT_SOF/IN_FRAME wait indefinitely.

## Test plan
- **Fixed run:** `i_num_frames`=3, `i_ipg_cycles`=4, enable → exactly 3 `o_start` pulses, each 5 cycles after the prior FD sample. `o_frame_count`=3, `o_done`=1, `o_busy`=0.
- **Zero IPG:** `i_ipg_cycles`=0, `i_num_frames`=2 → second `o_start` at T+1 after the first FD. Count=2, done.
- **Injection:** `i_stop_data_en`=1, `i_stop_data_frame`=1, `i_num_frames`=3 → `o_interrupt`=8'h02 only during frame 1. Frame 1 DATA bytes are 8'h00; frames 0 and 2 are unaffected.
- **Abort at terminate:** continuous mode, `i_abort` asserted in the same cycle as the 5th FD → count=5, DONE, no further `o_start`.
- **Abort in IPG:** `i_ipg_cycles`=10, `i_abort` in IPG → DONE next cycle, no further start. Then `i_enable`=0 → IDLE; re-enable → count restarts at 0.
- **Watchdog (with `MII_SCHED_WATCHDOG_EN`):** generator held in reset after `o_start` → `o_timeout`=1 after 128 cycles, stays 1 until `i_rst`. Without the macro, `o_timeout` stays 0 and `o_busy` stays 1.
